// File: rtl/nvme_delay_backend.sv
// rtl/nvme_delay_backend.sv - NVMe back-end latency model returning R/B responses a programmable delay after acceptance
module nvme_delay_backend #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512,
    parameter int DEPTH  = 16
) (
    input  logic              axi4_mm_clk,
    input  logic              axi4_mm_rst,
    input  logic              i_update,
    input  logic [63:0]       i_delay_cnt,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [ID_W-1:0]   s_arid,
    input  logic [ADDR_W-1:0] s_araddr,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [ID_W-1:0]   s_rid,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [ID_W-1:0]   s_awid,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_wvalid,
    output logic              s_wready,
    input  logic [DATA_W-1:0] s_wdata,
    input  logic              s_wlast,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic [ID_W-1:0]   s_bid,
    output logic [1:0]        s_bresp,
    output logic [63:0]       o_in_flight
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int REP = DATA_W / ADDR_W;

    logic [63:0] ts;
    logic [63:0] delay_q;

    logic [ID_W-1:0]   rd_id_mem   [DEPTH];
    logic [ADDR_W-1:0] rd_addr_mem [DEPTH];
    logic [63:0]       rd_due_mem  [DEPTH];
    logic [PW-1:0]     rd_wp, rd_rp;
    logic [CW-1:0]     rd_count, rd_cnt_nx;
    logic              rd_push, rd_pop, rd_full, rd_ready;

    logic [ID_W-1:0]   wr_id_mem   [DEPTH];
    logic [63:0]       wr_due_mem  [DEPTH];
    logic              wr_err_mem  [DEPTH];
    logic [PW-1:0]     wr_wp, wr_rp;
    logic [CW-1:0]     wr_count, wr_cnt_nx;
    logic              wr_push, wr_pop, wr_full, wr_ready;

    logic unused_inputs;
    assign unused_inputs = ^{s_awaddr, s_wdata};

    always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
        if (axi4_mm_rst) begin
            ts      <= '0;
            delay_q <= '0;
        end else begin
            ts <= ts + 64'd1;
            if (i_update) delay_q <= i_delay_cnt;
        end
    end

    // Stored due is one past ts+delay so that delay 0 surfaces the cycle after acceptance.
    assign rd_full   = (rd_count == CW'(DEPTH));
    assign s_arready = !rd_full;
    assign rd_push   = s_arvalid && !rd_full;
    assign rd_ready  = (rd_count != '0) && (ts >= rd_due_mem[rd_rp]);
    assign rd_pop    = rd_ready && s_rready;

    assign s_rvalid = rd_ready;
    assign s_rid    = rd_ready ? rd_id_mem[rd_rp] : '0;
    assign s_rdata  = rd_ready ? {REP{rd_addr_mem[rd_rp]}} : '0;
    assign s_rresp  = 2'b00;
    assign s_rlast  = rd_ready;

    always_ff @(posedge axi4_mm_clk) begin
        if (rd_push) begin
            rd_id_mem[rd_wp]   <= s_arid;
            rd_addr_mem[rd_wp] <= s_araddr;
            rd_due_mem[rd_wp]  <= ts + delay_q + 64'd1;
        end
    end

    always_comb begin
        rd_cnt_nx = rd_count;
        if (rd_push && !rd_pop)      rd_cnt_nx = rd_count + CW'(1);
        else if (!rd_push && rd_pop) rd_cnt_nx = rd_count - CW'(1);
    end

    always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
        if (axi4_mm_rst) begin
            rd_wp    <= '0;
            rd_rp    <= '0;
            rd_count <= '0;
        end else begin
            if (rd_push) rd_wp <= rd_wp + PW'(1);
            if (rd_pop)  rd_rp <= rd_rp + PW'(1);
            rd_count <= rd_cnt_nx;
        end
    end

    // AW and W are only ever taken together; write data itself is dropped.
    assign wr_full   = (wr_count == CW'(DEPTH));
    assign wr_push   = s_awvalid && s_wvalid && !wr_full;
    assign s_awready = wr_push;
    assign s_wready  = wr_push;
    assign wr_ready  = (wr_count != '0) && (ts >= wr_due_mem[wr_rp]);
    assign wr_pop    = wr_ready && s_bready;

    assign s_bvalid = wr_ready;
    assign s_bid    = wr_ready ? wr_id_mem[wr_rp] : '0;
    assign s_bresp  = (wr_ready && wr_err_mem[wr_rp]) ? 2'b10 : 2'b00;

    always_ff @(posedge axi4_mm_clk) begin
        if (wr_push) begin
            wr_id_mem[wr_wp]  <= s_awid;
            wr_due_mem[wr_wp] <= ts + delay_q + 64'd1;
            wr_err_mem[wr_wp] <= !s_wlast;
        end
    end

    always_comb begin
        wr_cnt_nx = wr_count;
        if (wr_push && !wr_pop)      wr_cnt_nx = wr_count + CW'(1);
        else if (!wr_push && wr_pop) wr_cnt_nx = wr_count - CW'(1);
    end

    always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
        if (axi4_mm_rst) begin
            wr_wp       <= '0;
            wr_rp       <= '0;
            wr_count    <= '0;
            o_in_flight <= '0;
        end else begin
            if (wr_push) wr_wp <= wr_wp + PW'(1);
            if (wr_pop)  wr_rp <= wr_rp + PW'(1);
            wr_count    <= wr_cnt_nx;
            o_in_flight <= 64'(rd_cnt_nx) + 64'(wr_cnt_nx);
        end
    end
endmodule

// File: tb/tb_nvme_delay_backend.sv
// tb/tb_nvme_delay_backend.sv - randomized bench for nvme_delay_backend against a queue-based latency model
module tb_nvme_delay_backend;
    localparam int ID_W   = 8;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 512;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              update = 1'b0;
    logic [63:0]       delay_cnt = '0;
    logic              arvalid = 1'b0, rready = 1'b0;
    logic [ID_W-1:0]   arid = '0;
    logic [ADDR_W-1:0] araddr = '0;
    logic              awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
    logic [ID_W-1:0]   awid = '0;
    logic [ADDR_W-1:0] awaddr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic              arready, rvalid, rlast, awready, wready, bvalid;
    logic [ID_W-1:0]   rid, bid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp, bresp;
    logic [63:0]       in_flight;

    always #5 clk = ~clk;

    nvme_delay_backend #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .axi4_mm_clk(clk), .axi4_mm_rst(rst), .i_update(update), .i_delay_cnt(delay_cnt),
        .s_arvalid(arvalid), .s_arready(arready), .s_arid(arid), .s_araddr(araddr),
        .s_rvalid(rvalid), .s_rready(rready), .s_rid(rid), .s_rdata(rdata),
        .s_rresp(rresp), .s_rlast(rlast),
        .s_awvalid(awvalid), .s_awready(awready), .s_awid(awid), .s_awaddr(awaddr),
        .s_wvalid(wvalid), .s_wready(wready), .s_wdata(wdata), .s_wlast(wlast),
        .s_bvalid(bvalid), .s_bready(bready), .s_bid(bid), .s_bresp(bresp),
        .o_in_flight(in_flight)
    );

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        longint unsigned   accepted;
        longint unsigned   lat;
    } rd_ent_t;
    typedef struct {
        logic [ID_W-1:0] id;
        longint unsigned accepted;
        longint unsigned lat;
        logic            err;
    } wr_ent_t;

    rd_ent_t         rq[$];
    wr_ent_t         wq[$];
    longint unsigned cyc = 0;
    longint unsigned mdelay = 0;
    int              n_checks = 0;
    int              n_pass = 0;
    bit              ar_hs = 0, aw_hs = 0;
    int              ar_left = 0, aw_left = 0;
    int              p_ar = 0, p_aw = 0, p_w = 0, p_r = 0, p_b = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // A response is due once strictly more than its latency has elapsed since acceptance.
    task automatic cycle();
        bit                e_rv, e_bv, e_ar, e_aw;
        logic [ID_W-1:0]   e_rid, e_bid;
        logic [DATA_W-1:0] e_rdata;
        logic [1:0]        e_bresp;
        @(negedge clk);
        if (rst) begin
            rq.delete();
            wq.delete();
            cyc = 0;
            mdelay = 0;
            ar_hs = 0;
            aw_hs = 0;
            check("rst_rvalid", rvalid, 0);
            check("rst_bvalid", bvalid, 0);
            check("rst_in_flight", in_flight, 0);
        end else begin
            e_rv = 0; e_rid = '0; e_rdata = '0;
            if (rq.size() > 0 && cyc > rq[0].accepted + rq[0].lat) begin
                e_rv = 1;
                e_rid = rq[0].id;
                e_rdata = {(DATA_W/ADDR_W){rq[0].addr}};
            end
            e_bv = 0; e_bid = '0; e_bresp = 2'b00;
            if (wq.size() > 0 && cyc > wq[0].accepted + wq[0].lat) begin
                e_bv = 1;
                e_bid = wq[0].id;
                e_bresp = wq[0].err ? 2'b10 : 2'b00;
            end
            e_ar = rq.size() < DEPTH;
            e_aw = awvalid && wvalid && (wq.size() < DEPTH);
            check("arready", arready, e_ar);
            check("rvalid", rvalid, e_rv);
            check("rid", rid, e_rid);
            check("rdata", rdata, e_rdata);
            check("rlast", rlast, e_rv);
            check("rresp", rresp, 0);
            check("awready", awready, e_aw);
            check("wready", wready, e_aw);
            check("bvalid", bvalid, e_bv);
            check("bid", bid, e_bid);
            check("bresp", bresp, e_bresp);
            check("in_flight", in_flight, rq.size() + wq.size());
            ar_hs = arvalid && e_ar;
            aw_hs = e_aw;
            if (e_rv && rready) void'(rq.pop_front());
            if (e_bv && bready) void'(wq.pop_front());
            if (ar_hs) rq.push_back('{id: arid, addr: araddr, accepted: cyc, lat: mdelay});
            if (aw_hs) wq.push_back('{id: awid, accepted: cyc, lat: mdelay, err: !wlast});
            if (update) mdelay = delay_cnt;
            cyc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        if (ar_hs) arvalid = 0;
        if (!arvalid && ar_left > 0 && $urandom_range(99) < p_ar) begin
            arvalid = 1;
            arid = ID_W'($urandom);
            araddr = {$urandom, $urandom};
            ar_left--;
        end
        if (aw_hs) begin
            awvalid = 0;
            wvalid = 0;
        end
        if (!awvalid && aw_left > 0 && $urandom_range(99) < p_aw) begin
            awvalid = 1;
            awid = ID_W'($urandom);
            awaddr = {$urandom, $urandom};
            aw_left--;
        end
        if (!wvalid && (awvalid || aw_left > 0) && $urandom_range(99) < p_w) begin
            wvalid = 1;
            wdata = {16{$urandom}};
            wlast = $urandom_range(99) < 75;
        end
        rready = $urandom_range(99) < p_r;
        bready = $urandom_range(99) < p_b;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            cycle();
            drive();
        end
    endtask

    task automatic set_delay(input longint unsigned d);
        update = 1;
        delay_cnt = d;
        cycle();
        drive();
        update = 0;
    endtask

    initial begin
        repeat (3) cycle();
        rst = 0;

        // single read, delay 10
        p_r = 100; p_b = 100;
        set_delay(10);
        run(3);
        arvalid = 1; arid = 8'd3; araddr = 64'h40;
        run(20);

        // single writes with delay 0, good and bad wlast
        set_delay(0);
        awvalid = 1; wvalid = 1; awid = 8'd7; wlast = 1;
        run(3);
        awvalid = 1; wvalid = 1; awid = 8'd8; wlast = 0;
        run(3);

        // fill the read queue past its depth with responses stalled
        set_delay(4);
        p_r = 0; p_ar = 100; ar_left = 17;
        run(30);
        check("t3_full_in_flight", in_flight, 16);
        check("t3_full_arready", arready, 0);
        p_r = 100;
        run(30);
        check("t3_drained_in_flight", in_flight, 0);

        // lone AW must wait for W
        p_aw = 100; aw_left = 1; p_w = 0;
        run(20);
        check("t4_lone_aw_ready", awready, 0);
        p_w = 100;
        run(10);

        // random interleaved traffic with ready stalls and delay changes
        ar_left = 100000; aw_left = 100000;
        for (int k = 0; k < 8; k++) begin
            set_delay($urandom_range(12));
            p_ar = $urandom_range(20, 100);
            p_aw = $urandom_range(20, 100);
            p_w  = $urandom_range(20, 100);
            p_r  = $urandom_range(10, 90);
            p_b  = $urandom_range(10, 90);
            run(60);
        end
        ar_left = 0; aw_left = 0; p_r = 100; p_b = 100;
        run(40);

        // reset with entries queued
        set_delay(50);
        p_r = 0; p_b = 0; p_ar = 100; p_aw = 100; p_w = 100;
        ar_left = 3; aw_left = 2;
        run(12);
        check("t6_queued", in_flight, 5);
        rst = 1;
        cycle();
        cycle();
        rst = 0;
        arvalid = 0; awvalid = 0; wvalid = 0;
        ar_left = 0; aw_left = 0; p_r = 100; p_b = 100;
        run(80);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
